// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption engine.
// One round datapath is reused for all ten rounds, one round per clock. The round key
// is expanded on the fly alongside the state. Valid/ready on both sides, one block in flight.
module aes128_encrypt_iter #(
    parameter bit ZEROIZE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // GF(2^8) multiply by x, modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // S-box computed as multiplicative inverse (a^254, which maps 0 to 0) plus affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    // One AES round: SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
    // Byte i lives at bits [127-8i -: 8]; byte i sits at row i%4, column i/4.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ k;
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] data_out_q, data_out_d;

    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3, rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] nrk;
    logic [127:0] round_out;

    // Round constant for the key being produced in the current round.
    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0    = rk_q[127:96];
    assign w1    = rk_q[95:64];
    assign w2    = rk_q[63:32];
    assign w3    = rk_q[31:0];
    assign rot_w = {w3[23:0], w3[31:24]};

    // SubWord: four S-boxes on the rotated last word.
    for (genvar g = 0; g < 4; g++) begin : g_subword
        assign sub_w[8*g +: 8] = sbox(rot_w[8*g +: 8]);
    end

    assign t_w       = sub_w ^ {rcon, 24'h000000};
    assign n0        = w0 ^ t_w;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign nrk       = {n0, n1, n2, n3};
    assign round_out = aes_round(state_q, nrk, round_q == 4'd10);

    // Next-state logic for the control FSM and the datapath registers.
    always_comb begin
        fsm_d      = fsm_q;
        round_d    = round_q;
        state_d    = state_q;
        rk_d       = rk_q;
        data_out_d = data_out_q;
        case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = plaintext ^ key;
                    rk_d    = key;
                    round_d = 4'd1;
                    fsm_d   = StRun;
                end
            end
            StRun: begin
                state_d = round_out;
                rk_d    = nrk;
                if (round_q == 4'd10) begin
                    data_out_d = round_out;
                    fsm_d      = StDone;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    fsm_d   = StIdle;
                    round_d = 4'd0;
                    if (ZEROIZE) begin
                        state_d    = '0;
                        rk_d       = '0;
                        data_out_d = '0;
                    end
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any block in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q      <= StIdle;
            round_q    <= 4'd0;
            state_q    <= '0;
            rk_q       <= '0;
            data_out_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            round_q    <= round_d;
            state_q    <= state_d;
            rk_q       <= rk_d;
            data_out_q <= data_out_d;
        end
    end

    assign in_ready  = (fsm_q == StIdle);
    assign out_valid = (fsm_q == StDone);
    assign busy      = (fsm_q == StRun) || (fsm_q == StDone);
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter using FIPS-197 vectors and a scoreboard queue.
module tb_aes128_encrypt_iter;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] plaintext, key, data_out;

    logic         nz_in_valid, nz_in_ready, nz_out_valid, nz_out_ready, nz_busy;
    logic [127:0] nz_plaintext, nz_key, nz_data_out;

    int           n_checks = 0;
    int           n_fails  = 0;
    int           cyc      = 0;
    logic         ov_prev  = 1'b0;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    int           emit_q[$];

    aes128_encrypt_iter #(.ZEROIZE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .plaintext (plaintext),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    aes128_encrypt_iter #(.ZEROIZE(1'b0)) dut_nz (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (nz_in_valid),
        .in_ready  (nz_in_ready),
        .plaintext (nz_plaintext),
        .key       (nz_key),
        .out_valid (nz_out_valid),
        .out_ready (nz_out_ready),
        .data_out  (nz_data_out),
        .busy      (nz_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Known-answer lookup for the vectors this bench drives.
    function automatic logic [127:0] ref_ct(input logic [127:0] p, input logic [127:0] k);
        if (p == PT1 && k == K1) return CT1;
        if (p == PT2 && k == K2) return CT2;
        return '0;
    endfunction

    // Scoreboard: push on accept, check latency on out_valid rise, pop and compare on emit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_ct(plaintext, key));
                acc_q.push_back(cyc + 1);
            end
            if (out_valid && !ov_prev) begin
                check_eq("latency", cyc - ((acc_q.size() > 0) ? acc_q.pop_front() : -1000), 10);
            end
            if (out_valid && out_ready) begin
                check_eq("ciphertext", data_out, (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
                emit_q.push_back(cyc);
            end
        end
        ov_prev = out_valid;
    end

    task automatic send(input logic [127:0] p, input logic [127:0] k);
        @(posedge clk);
        #1;
        plaintext = p;
        key       = k;
        in_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check_eq("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        plaintext = ~p;  // inputs may change after acceptance
        key       = ~k;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        plaintext    = '0;
        key          = '0;
        nz_in_valid  = 1'b0;
        nz_out_ready = 1'b0;
        nz_plaintext = '0;
        nz_key       = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_nz_data_out", nz_data_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // FIPS-197 App.B and App.C.1
        out_ready = 1'b1;
        send(PT1, K1);
        @(negedge clk);
        check_eq("run_busy", busy, 1);
        check_eq("run_in_ready", in_ready, 0);
        wait_drain(40);
        send(PT2, K2);
        wait_drain(40);

        // Back-pressure: output held, second request ignored, zeroized after handshake
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(PT1, K1);
        for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
        check_eq("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            plaintext = PT2;
            key       = K2;
            @(negedge clk);
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_data_out", data_out, CT1);
            check_eq("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_idle_in_ready", in_ready, 1);
        check_eq("bp_idle_out_valid", out_valid, 0);
        check_eq("bp_idle_busy", busy, 0);
        check_eq("zeroize_data_out", data_out, 0);
        check_eq("bp_sb_empty", exp_q.size(), 0);

        // Reset during round 5 drops the block
        send(PT1, K1);
        @(negedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_data_out", data_out, 0);
        send(PT2, K2);
        wait_drain(40);

        // Back-to-back with in_valid held: 10 RUN cycles + DONE + IDLE accept cycle apart
        @(posedge clk);
        #1;
        emit_q.delete();
        plaintext = PT1;
        key       = K1;
        in_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk);
        #1;
        plaintext = PT2;
        key       = K2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_drain(60);
        @(negedge clk);
        check_eq("b2b_count", emit_q.size(), 2);
        if (emit_q.size() == 2) check_eq("b2b_spacing", emit_q[1] - emit_q[0], 12);

        // ZEROIZE=0 keeps the ciphertext after the handshake
        @(posedge clk);
        #1;
        nz_out_ready = 1'b1;
        nz_plaintext = PT2;
        nz_key       = K2;
        nz_in_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (nz_in_ready) break;
        end
        @(posedge clk);
        #1 nz_in_valid = 1'b0;
        for (int i = 0; i < 30 && !nz_out_valid; i++) @(negedge clk);
        check_eq("nz_valid_seen", nz_out_valid, 1);
        check_eq("nz_ciphertext", nz_data_out, CT2);
        @(negedge clk);
        check_eq("nz_after_out_valid", nz_out_valid, 0);
        check_eq("nz_after_in_ready", nz_in_ready, 1);
        check_eq("nz_hold_data_out", nz_data_out, CT2);

        check_eq("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
